vpu_pipe_ctrl: RTL

VPU_PIPE_CTRL -- requirements
Module: vpu_pipe_ctrl

---
 rtl/vpu_pkg.sv | 29 ++
 rtl/vpu_req_fifo.sv | 70 +++++++
 rtl/vpu_pipe_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// Shared types for the vector pipe controller.
//   slot_state_t : lifecycle of one pipeline stage slot (IDLE -> BUSY -> DONE)
//   vpu_req_t    : request payload as stored in the queue and the stage slots
//   slot_active  : helper, true when a slot holds work (BUSY or DONE)
// Payload storage widths are fixed here; the controller's width parameters
// default to these values and resize at the ports.
package vpu_pkg;

    localparam int VPU_OP_W  = 4;
    localparam int VPU_DLY_W = 4;
    localparam int VPU_TAG_W = 4;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_BUSY = 2'd1,
        SLOT_DONE = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic [VPU_OP_W-1:0]  op;
        logic [VPU_DLY_W-1:0] dly;
        logic [VPU_TAG_W-1:0] tag;
    } vpu_req_t;

    function automatic logic slot_active(input slot_state_t s);
        return (s != SLOT_IDLE);
    endfunction

endpackage

// File: rtl/vpu_req_fifo.sv
// In-order request queue, first-word-fall-through.
//   clk, rst     : clock, synchronous active-high reset (empties the queue)
//   i_push/i_push_data : write one entry (ignored while full)
//   i_pop        : drop the head entry (ignored while empty)
//   o_head_data  : current head entry, valid whenever o_empty is low
//   o_full, o_empty, o_count : occupancy status
module vpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is read combinationally so the stage logic can consume it in
    // the same cycle it decides to load the operand-fetch slot.
    assign o_head_data = r_mem[r_rd_ptr];
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;

endmodule

// File: rtl/vpu_pipe_ctrl.sv
// Three-stage (operand fetch, execute, writeback) pipeline controller.
// Requests are queued in order, then walk through OPG -> EXE -> WB slots;
// each slot start is a one-cycle pulse and each stage reports completion
// through its *_done_i. A finished writeback produces a completion pulse
// one cycle later.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid_i/req_ready_o       : request handshake
//   req_op_i/req_delay_i/req_tag_i: request payload
//   opget_*                       : operand-fetch stage start/tag/done
//   exec_*                        : execute stage start/op/delay/done
//   wb_*                          : writeback stage start/tag/done
//   cpl_valid_o/cpl_tag_o         : completion pulse
//   busy_o/inflight_o             : queued + in-slot request count
module vpu_pipe_ctrl
    import vpu_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int OP_W      = VPU_OP_W,
    parameter int DLY_W     = VPU_DLY_W,
    parameter int TAG_W     = VPU_TAG_W,
    parameter int PIPELINED = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [OP_W-1:0]              req_op_i,
    input  logic [DLY_W-1:0]             req_delay_i,
    input  logic [TAG_W-1:0]             req_tag_i,
    output logic                         opget_start_o,
    output logic [TAG_W-1:0]             opget_tag_o,
    input  logic                         opget_done_i,
    output logic                         exec_start_o,
    output logic [OP_W-1:0]              exec_op_o,
    output logic [DLY_W-1:0]             exec_delay_o,
    input  logic                         exec_done_i,
    output logic                         wb_start_o,
    output logic [TAG_W-1:0]             wb_tag_o,
    input  logic                         wb_done_i,
    output logic                         cpl_valid_o,
    output logic [TAG_W-1:0]             cpl_tag_o,
    output logic                         busy_o,
    output logic [$clog2(REQ_DEPTH)+2:0] inflight_o
);

    localparam int CNT_W = $clog2(REQ_DEPTH) + 1;
    localparam int IF_W  = $clog2(REQ_DEPTH) + 3;

    vpu_req_t               w_push_pl;
    vpu_req_t               w_head_pl;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CNT_W-1:0]       w_fifo_count;

    slot_state_t            r_opg_st, r_exe_st, r_wb_st;
    slot_state_t            w_opg_st_next, w_exe_st_next, w_wb_st_next;
    vpu_req_t               r_opg_pl, r_exe_pl;
    logic [VPU_TAG_W-1:0]   r_wb_tag;
    logic                   r_cpl_valid;
    logic [VPU_TAG_W-1:0]   r_cpl_tag;

    logic w_wb_fin, w_wb_free;
    logic w_exe_fin, w_exe_xfer, w_exe_free;
    logic w_opg_fin, w_opg_xfer, w_opg_free;
    logic w_all_idle, w_issue_ok, w_opg_load;

    assign w_push_pl = '{op: VPU_OP_W'(req_op_i), dly: VPU_DLY_W'(req_delay_i),
                         tag: VPU_TAG_W'(req_tag_i)};
    assign req_ready_o = !w_fifo_full;

    vpu_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH ($bits(vpu_req_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (req_valid_i && req_ready_o),
        .i_push_data (w_push_pl),
        .i_pop       (w_opg_load),
        .o_head_data (w_head_pl),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // A slot counts as finished either when already DONE or when BUSY and
    // its done arrives now, so a free downstream slot lets work move on in
    // the done cycle itself. Done is only honoured in BUSY, which is entered
    // on the edge after the start pulse, so a done in the start cycle is
    // ignored. WB never parks in DONE: its done frees it outright.
    assign w_wb_fin   = (r_wb_st == SLOT_BUSY) && wb_done_i;
    assign w_wb_free  = (r_wb_st == SLOT_IDLE) || w_wb_fin;

    assign w_exe_fin  = (r_exe_st == SLOT_DONE) || ((r_exe_st == SLOT_BUSY) && exec_done_i);
    assign w_exe_xfer = !rst && w_exe_fin && w_wb_free;
    assign w_exe_free = (r_exe_st == SLOT_IDLE) || w_exe_xfer;

    assign w_opg_fin  = (r_opg_st == SLOT_DONE) || ((r_opg_st == SLOT_BUSY) && opget_done_i);
    assign w_opg_xfer = !rst && w_opg_fin && w_exe_free;
    assign w_opg_free = (r_opg_st == SLOT_IDLE) || w_opg_xfer;

    // Non-pipelined mode issues only into a completely empty pipe, so the
    // next operand fetch never starts before the previous completion pulse.
    assign w_all_idle = (r_opg_st == SLOT_IDLE) && (r_exe_st == SLOT_IDLE) &&
                        (r_wb_st == SLOT_IDLE);
    assign w_issue_ok = (PIPELINED != 0) || w_all_idle;
    assign w_opg_load = !rst && !w_fifo_empty && w_opg_free && w_issue_ok;

    always_comb begin
        w_opg_st_next = r_opg_st;
        w_exe_st_next = r_exe_st;
        w_wb_st_next  = r_wb_st;

        if (w_opg_load) begin
            w_opg_st_next = SLOT_BUSY;
        end else if (w_opg_xfer) begin
            w_opg_st_next = SLOT_IDLE;
        end else if ((r_opg_st == SLOT_BUSY) && opget_done_i) begin
            w_opg_st_next = SLOT_DONE;
        end

        if (w_opg_xfer) begin
            w_exe_st_next = SLOT_BUSY;
        end else if (w_exe_xfer) begin
            w_exe_st_next = SLOT_IDLE;
        end else if ((r_exe_st == SLOT_BUSY) && exec_done_i) begin
            w_exe_st_next = SLOT_DONE;
        end

        if (w_exe_xfer) begin
            w_wb_st_next = SLOT_BUSY;
        end else if (w_wb_fin) begin
            w_wb_st_next = SLOT_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opg_st    <= SLOT_IDLE;
            r_exe_st    <= SLOT_IDLE;
            r_wb_st     <= SLOT_IDLE;
            r_opg_pl    <= '0;
            r_exe_pl    <= '0;
            r_wb_tag    <= '0;
            r_cpl_valid <= 1'b0;
            r_cpl_tag   <= '0;
        end else begin
            r_opg_st    <= w_opg_st_next;
            r_exe_st    <= w_exe_st_next;
            r_wb_st     <= w_wb_st_next;
            if (w_opg_load) begin
                r_opg_pl <= w_head_pl;
            end
            if (w_opg_xfer) begin
                r_exe_pl <= r_opg_pl;
            end
            if (w_exe_xfer) begin
                r_wb_tag <= r_exe_pl.tag;
            end
            r_cpl_valid <= w_wb_fin;
            r_cpl_tag   <= w_wb_fin ? r_wb_tag : '0;
        end
    end

    assign opget_start_o = w_opg_load;
    assign exec_start_o  = w_opg_xfer;
    assign wb_start_o    = w_exe_xfer;

    assign opget_tag_o  = slot_active(r_opg_st) ? TAG_W'(r_opg_pl.tag) : '0;
    assign exec_op_o    = slot_active(r_exe_st) ? OP_W'(r_exe_pl.op)   : '0;
    assign exec_delay_o = slot_active(r_exe_st) ? DLY_W'(r_exe_pl.dly) : '0;
    assign wb_tag_o     = slot_active(r_wb_st)  ? TAG_W'(r_wb_tag)     : '0;

    assign cpl_valid_o = r_cpl_valid;
    assign cpl_tag_o   = TAG_W'(r_cpl_tag);

    assign inflight_o = IF_W'(w_fifo_count) + IF_W'(slot_active(r_opg_st)) +
                        IF_W'(slot_active(r_exe_st)) + IF_W'(slot_active(r_wb_st));
    assign busy_o     = (inflight_o != '0);

endmodule
